rbcp_regfile_bridge: RTL

//  Parametrised RBCP-to-register-file bridge: maps N_WR 32-bit control words and N_RD 32-bit status

---
 rtl/rbcp_regfile_bridge.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rbcp_regfile_bridge.sv
// RBCP byte bus to 32-bit register-file bridge: N_WR committed control words, N_RD snapshotted status words.
// Latency: one cycle from accepted request to rbcp_ack / rbcp_rd; strobes align with the ack cycle.
// Backpressure: none; a request may be accepted every cycle. Optional macro RBCP_REG_READBACK_EN.
module rbcp_regfile_bridge #(
  parameter int          N_WR    = 2,
  parameter int          N_RD    = 2,
  parameter logic [31:0] WR_BASE = 32'h0000_0000,
  parameter logic [31:0] RD_BASE = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rbcp_act,
  input  logic [31:0]          rbcp_addr,
  input  logic                 rbcp_we,
  input  logic [7:0]           rbcp_wd,
  input  logic                 rbcp_re,
  output logic [7:0]           rbcp_rd,
  output logic                 rbcp_ack,
  output logic [32*N_WR-1:0]   reg_out,
  output logic [N_WR-1:0]      reg_out_upd,
  input  logic [32*N_RD-1:0]   reg_in,
  output logic [N_RD-1:0]      reg_in_snap
);

  localparam int          WW      = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int          RW      = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam logic [31:0] WR_SPAN = 32'(4 * N_WR);
  localparam logic [31:0] RD_SPAN = 32'(4 * N_RD);

  // Big-endian lane extraction: lane 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    logic [7:0] b;
    case (l)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Big-endian lane replacement inside a word.
  function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] l,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (l)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  logic [N_RD-1:0][31:0] reg_in_w;
  assign reg_in_w = reg_in;

  logic [N_WR-1:0][31:0] shadow_q, shadow_d;
  logic [N_WR-1:0][31:0] reg_out_q, reg_out_d;
  logic [N_WR-1:0]       upd_q, upd_d;
  logic [N_RD-1:0][31:0] snap_q, snap_d;
  logic [N_RD-1:0]       snap_stb_q, snap_stb_d;
  logic                  ack_q, ack_d;
  logic [7:0]            rd_q, rd_d;

  // Address decode: full 32-bit range checks so no upper-bit aliasing is possible.
  logic [31:0]   wr_off, rd_off;
  logic          wr_hit, rd_hit, req;
  logic [WW-1:0] wr_idx;
  logic [RW-1:0] rd_idx;
  logic [1:0]    lane;

  assign wr_off = rbcp_addr - WR_BASE;
  assign rd_off = rbcp_addr - RD_BASE;
  assign wr_hit = (rbcp_addr >= WR_BASE) && (wr_off < WR_SPAN);
  assign rd_hit = (rbcp_addr >= RD_BASE) && (rd_off < RD_SPAN);
  assign wr_idx = wr_off[WW+1:2];
  assign rd_idx = rd_off[RW+1:2];
  assign lane   = rbcp_addr[1:0];
  assign req    = rbcp_act && (rbcp_we || rbcp_re);

  // Next-state: shadow/commit on writes, snapshot/return on reads; write wins over read.
  always_comb begin
    shadow_d   = shadow_q;
    reg_out_d  = reg_out_q;
    upd_d      = '0;
    snap_d     = snap_q;
    snap_stb_d = '0;
    ack_d      = 1'b0;
    rd_d       = 8'h00;
    if (req) begin
      ack_d = 1'b1;
      if (rbcp_we) begin
        if (wr_hit) begin
          shadow_d[wr_idx] = lane_put(shadow_q[wr_idx], lane, rbcp_wd);
          if (lane == 2'd3) begin
            // Commit the whole word at once from the shadow plus the incoming low byte.
            reg_out_d[wr_idx] = {shadow_q[wr_idx][31:8], rbcp_wd};
            upd_d[wr_idx]     = 1'b1;
          end
        end
      end else if (rd_hit) begin
        if (lane == 2'd0) begin
          // Lane 0 freezes the live word so lanes 1..3 read a coherent value.
          snap_d[rd_idx]     = reg_in_w[rd_idx];
          snap_stb_d[rd_idx] = 1'b1;
          rd_d               = reg_in_w[rd_idx][31:24];
        end else begin
          rd_d = lane_byte(snap_q[rd_idx], lane);
        end
      end
`ifdef RBCP_REG_READBACK_EN
      else if (wr_hit) begin
        rd_d = lane_byte(reg_out_q[wr_idx], lane);
      end
`endif
    end
  end

  // State registers; reset discards any request accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      reg_out_q  <= '0;
      upd_q      <= '0;
      snap_q     <= '0;
      snap_stb_q <= '0;
      ack_q      <= 1'b0;
      rd_q       <= 8'h00;
    end else begin
      shadow_q   <= shadow_d;
      reg_out_q  <= reg_out_d;
      upd_q      <= upd_d;
      snap_q     <= snap_d;
      snap_stb_q <= snap_stb_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
    end
  end

  assign rbcp_ack    = ack_q;
  assign rbcp_rd     = rd_q;
  assign reg_out     = reg_out_q;
  assign reg_out_upd = upd_q;
  assign reg_in_snap = snap_stb_q;

endmodule
